// File: rtl/fsk2_tx_sched_if.sv
// Requester and transmitter signals of the 2FSK transmit scheduler.
// The master side is the environment (requesters and transmitter); the slave side is the scheduler.
interface fsk2_tx_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 3
);
  logic                  en;
  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    ack;
  logic [15:0]           tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic [PTR_W-1:0]      active_id;
  logic                  frame_done;
  logic                  err_timeout;
  logic                  sched_busy;

  modport master (
    output en, req, req_data, tx_busy,
    input  ack, tx_data, tx_start, active_id, frame_done, err_timeout, sched_busy
  );

  modport slave (
    input  en, req, req_data, tx_busy,
    output ack, tx_data, tx_start, active_id, frame_done, err_timeout, sched_busy
  );
endinterface

// File: rtl/fsk2_tx_sched.sv
// Round-robin arbiter that hands one shared 2FSK transmitter to NUM_REQ requesters,
// one 16-bit frame at a time, with a start-timeout and an idle guard gap between frames.
module fsk2_tx_sched #(
  parameter int NUM_REQ       = 4,
  parameter int GAP_CLKS      = 100,
  parameter int START_TIMEOUT = 200,
  parameter int PTR_W         = 3
) (
  input logic            sys_clk,
  input logic            sys_rst,
  fsk2_tx_sched_if.slave bus
);

  localparam int TMR_MAX = (GAP_CLKS > START_TIMEOUT) ? GAP_CLKS : START_TIMEOUT;
  localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] WAIT_LAST = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, SEND, GAP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [TMR_W-1:0]   timer;
  logic [NUM_REQ-1:0] ack_r;
  logic [15:0]        tx_data_r;
  logic               tx_start_r;
  logic [PTR_W-1:0]   active_id_r;
  logic               frame_done_r;
  logic               err_timeout_r;
  logic               sched_busy_r;

  logic               grant_hit;
  logic [PTR_W-1:0]   grant_idx;
  logic [15:0]        grant_word;
  logic [PTR_W-1:0]   ptr_next;

  // Two passes give the rotating priority: first requesters at or above rr_ptr,
  // then (only if none found) the ones below it.
  always_comb begin
    grant_hit  = 1'b0;
    grant_idx  = '0;
    grant_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_hit && bus.req[i] && (PTR_W'(i) >= rr_ptr)) begin
        grant_hit  = 1'b1;
        grant_idx  = PTR_W'(i);
        grant_word = bus.req_data[16*i +: 16];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_hit && bus.req[i]) begin
        grant_hit  = 1'b1;
        grant_idx  = PTR_W'(i);
        grant_word = bus.req_data[16*i +: 16];
      end
    end
  end

  assign ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      timer         <= '0;
      ack_r         <= '0;
      tx_data_r     <= '0;
      tx_start_r    <= 1'b0;
      active_id_r   <= '0;
      frame_done_r  <= 1'b0;
      err_timeout_r <= 1'b0;
      sched_busy_r  <= 1'b0;
    end else begin
      ack_r         <= '0;
      tx_start_r    <= 1'b0;
      frame_done_r  <= 1'b0;
      err_timeout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.en && grant_hit) begin
            tx_data_r    <= grant_word;
            ack_r        <= NUM_REQ'(1) << grant_idx;
            active_id_r  <= grant_idx;
            rr_ptr       <= ptr_next;
            sched_busy_r <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          tx_start_r <= 1'b1;
          timer      <= '0;
          state      <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= SEND;
          end else if (timer == WAIT_LAST) begin
            err_timeout_r <= 1'b1;
            timer         <= '0;
            state         <= GAP;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        SEND: begin
          if (!bus.tx_busy) begin
            frame_done_r <= 1'b1;
            timer        <= '0;
            state        <= GAP;
          end
        end
        GAP: begin
          if ((GAP_CLKS == 0) || (timer == GAP_LAST)) begin
            sched_busy_r <= 1'b0;
            state        <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          sched_busy_r <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack         = ack_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.tx_start    = tx_start_r;
  assign bus.active_id   = active_id_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.err_timeout = err_timeout_r;
  assign bus.sched_busy  = sched_busy_r;

endmodule

// File: tb/tb_fsk2_tx_sched.sv
// Directed bench for fsk2_tx_sched: grant order, frame timing, start timeout,
// enable gating and mid-frame reset, with a simple transmitter model driven inline.
module tb_fsk2_tx_sched;

  localparam int NUM_REQ = 4;
  localparam int PTR_W   = 3;
  localparam int GAP     = 100;
  localparam int TMO     = 200;

  logic sys_clk;
  logic sys_rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  fsk2_tx_sched_if #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) bus ();

  fsk2_tx_sched #(
    .NUM_REQ(NUM_REQ), .GAP_CLKS(GAP), .START_TIMEOUT(TMO), .PTR_W(PTR_W)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Wait for the next ack; exp_cnt < 0 skips the latency check.
  task automatic wait_grant(input string tag, input int exp_cnt);
    int cnt;
    cnt = 0;
    while (bus.ack == '0 && cnt < 400) begin
      tick();
      cnt++;
    end
    chk({tag, "_timeout"}, 32'(bus.ack == '0), 0);
    if (exp_cnt >= 0) chk({tag, "_latency"}, 32'(cnt), 32'(exp_cnt));
  endtask

  // Called in the cycle the ack is visible; plays the transmitter for one full frame.
  task automatic grant_frame(input string tag, input int exp_id, input logic [15:0] exp_word,
                             input int busy_len, input logic [3:0] nreq, input logic drop_en);
    chk({tag, "_ack"}, 32'(bus.ack), 32'(1) << exp_id);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'(exp_word));
    chk({tag, "_active_id"}, 32'(bus.active_id), 32'(exp_id));
    chk({tag, "_sched_busy"}, 32'(bus.sched_busy), 1);
    bus.req = nreq;
    tick();
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 1);
    chk({tag, "_ack_pulse"}, 32'(bus.ack), 0);
    tick();
    chk({tag, "_tx_start_pulse"}, 32'(bus.tx_start), 0);
    tick();
    bus.tx_busy = 1'b1;
    for (int c = 0; c < busy_len; c++) begin
      tick();
      if (drop_en && c == busy_len / 2) bus.en = 1'b0;
    end
    chk({tag, "_no_early_done"}, 32'(bus.frame_done), 0);
    chk({tag, "_data_hold"}, 32'(bus.tx_data), 32'(exp_word));
    bus.tx_busy = 1'b0;
    tick();
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 1);
    chk({tag, "_no_timeout"}, 32'(bus.err_timeout), 0);
  endtask

  initial begin
    int          cnt;
    int          acks;
    logic        fd_seen;
    logic [15:0] words [4];
    int          order [5];
    words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    order = '{0, 1, 2, 3, 0};

    bus.en       = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    sys_rst      = 1'b1;
    tick();
    tick();
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_sched_busy", 32'(bus.sched_busy), 0);
    chk("rst_active_id", 32'(bus.active_id), 0);
    sys_rst = 1'b0;
    tick();
    chk("idle_sched_busy", 32'(bus.sched_busy), 0);

    // Single requester, 800-cycle frame, then gap latency to the next grant.
    bus.req_data[15:0] = 16'hA5C3;
    bus.req            = 4'b0001;
    bus.en             = 1'b1;
    tick();
    chk("single_ack_latency", 32'(bus.ack), 1);
    bus.req_data[15:0] = 16'h5A3C;
    grant_frame("single", 0, 16'hA5C3, 800, 4'b0001, 1'b0);
    tick();
    chk("gap_data_hold", 32'(bus.tx_data), 32'(16'hA5C3));
    chk("gap_no_ack", 32'(bus.ack), 0);
    wait_grant("single_regrant", GAP);
    grant_frame("single2", 0, 16'h5A3C, 5, 4'b0000, 1'b0);

    // Reset in GAP puts rr_ptr back to 0, then all four request continuously.
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    bus.req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    bus.req      = 4'b1111;
    wait_grant("rr_first", 1);
    for (int j = 0; j < 5; j++) begin
      grant_frame("rr", order[j], words[order[j]], 5, (j == 4) ? 4'b0010 : 4'b1111, 1'b0);
      wait_grant("rr_next", GAP + 1);
    end

    // rr_ptr is now 2 after granting requester 1; 4'b1001 must go 3 then wrap to 0.
    grant_frame("to_ptr2", 1, 16'h2222, 5, 4'b1001, 1'b0);
    wait_grant("wrap_a", GAP + 1);
    grant_frame("wrap3", 3, 16'h4444, 5, 4'b1001, 1'b0);
    wait_grant("wrap_b", GAP + 1);
    chk("wrap0_ack", 32'(bus.ack), 1);
    chk("wrap0_data", 32'(bus.tx_data), 32'(16'h1111));

    // tx_busy never rises: timeout, no frame_done, then GAP back to IDLE.
    bus.req = 4'b0000;
    tick();
    chk("tmo_tx_start", 32'(bus.tx_start), 1);
    cnt     = 0;
    fd_seen = 1'b0;
    while (!bus.err_timeout && cnt < 400) begin
      tick();
      cnt++;
      if (bus.frame_done) fd_seen = 1'b1;
    end
    chk("tmo_latency", 32'(cnt), 32'(TMO));
    tick();
    chk("tmo_pulse_len", 32'(bus.err_timeout), 0);
    cnt = 1;
    while (bus.sched_busy && cnt < 400) begin
      tick();
      cnt++;
      if (bus.frame_done) fd_seen = 1'b1;
    end
    chk("tmo_gap_len", 32'(cnt), 32'(GAP));
    chk("tmo_no_frame_done", 32'(fd_seen), 0);

    // en gating: pending request waits, grant follows en, dropping en mid-SEND blocks the next grant.
    bus.en  = 1'b0;
    bus.req = 4'b0010;
    repeat (5) tick();
    chk("en0_no_ack", 32'(bus.ack), 0);
    chk("en0_idle", 32'(bus.sched_busy), 0);
    bus.en = 1'b1;
    tick();
    grant_frame("en_frame", 1, 16'h2222, 20, 4'b0010, 1'b1);
    acks = 0;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (bus.ack != '0) acks++;
    end
    chk("en_drop_no_grant", 32'(acks), 0);
    chk("en_drop_idle", 32'(bus.sched_busy), 0);

    // Reset during SEND.
    bus.en = 1'b1;
    tick();
    chk("rst_send_ack", 32'(bus.ack), 32'(4'b0010));
    bus.req = 4'b0000;
    tick();
    chk("rst_send_tx_start", 32'(bus.tx_start), 1);
    tick();
    tick();
    bus.tx_busy = 1'b1;
    repeat (5) tick();
    sys_rst = 1'b1;
    tick();
    chk("midrst_ack", 32'(bus.ack), 0);
    chk("midrst_tx_data", 32'(bus.tx_data), 0);
    chk("midrst_tx_start", 32'(bus.tx_start), 0);
    chk("midrst_frame_done", 32'(bus.frame_done), 0);
    chk("midrst_err_timeout", 32'(bus.err_timeout), 0);
    chk("midrst_active_id", 32'(bus.active_id), 0);
    chk("midrst_sched_busy", 32'(bus.sched_busy), 0);
    sys_rst     = 1'b0;
    bus.tx_busy = 1'b0;
    bus.req     = 4'b1111;
    tick();
    chk("postrst_ack", 32'(bus.ack), 1);
    chk("postrst_data", 32'(bus.tx_data), 32'(16'h1111));
    chk("postrst_no_done", 32'(bus.frame_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
